ma_cvxif_responder: RTL and testbench
=====================================

Name: ma_cvxif_responder

Overview:
Coprocessor-side CVXIF responder for the matrix accelerator. CVA6, with CvxifEn=1 and XLEN=32, is the initiator. This block decodes offloaded custom-0 instructions and holds accepted ones in an in-order queue until commit or kill. It dispatches committed instructions to the accelerator command port and returns accelerator responses to CVA6 on the result channel.

Parameters:
XLEN, 32, data/operand width (matches core XLEN)
ID_WIDTH, 3, CVXIF instruction id width
DEPTH, 4, queue entries (power of 2, >=2)
OPCODE, 7'h0B, major opcode claimed by the accelerator (custom-0)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
issue_valid_i  in  1  issue request valid
issue_ready_o  out  1  issue request ready
issue_instr_i  in  32  offloaded instruction
issue_id_i  in  ID_WIDTH  instruction id
issue_rs1_i  in  XLEN  rs1 value (valid with issue)
issue_rs2_i  in  XLEN  rs2 value (valid with issue)
issue_accept_o  out  1  instruction claimed (meaningful during issue handshake)
issue_writeback_o  out  1  instruction will write rd
commit_valid_i  in  1  commit event
commit_id_i  in  ID_WIDTH  committed id
commit_kill_i  in  1  1 = kill, 0 = commit
result_valid_o  out  1  result valid
result_ready_i  in  1  result ready
result_id_o  out  ID_WIDTH  result id
result_data_o  out  XLEN  writeback data
result_rd_o  out  5  destination register
result_we_o  out  1  write enable
cmd_valid_o  out  1  accelerator command valid
cmd_ready_i  in  1  accelerator command ready
cmd_funct_o  out  10  {funct7, funct3}
cmd_rs1_o  out  XLEN  operand 1
cmd_rs2_o  out  XLEN  operand 2
rsp_valid_i  in  1  accelerator response valid
rsp_ready_o  out  1  accelerator response ready
rsp_data_i  in  XLEN  response data

Behaviour:
- Reset: all *_valid_o, rsp_ready_o, issue_accept_o, issue_writeback_o and result fields = 0. Queue emptied, FSM in IDLE. Reset mid-operation discards all entries and any outstanding accelerator transaction.
- Decode (combinational): accept = instr[6:0]==OPCODE && funct3!=3'b111. writeback = accept && funct3<=3'b011 && rd!=0.
- issue_ready_o = (count<DEPTH), from registered count with no same-cycle pop bypass. A non-accepted instruction still completes its handshake, with accept=0 and no entry allocated.
- Entry fields: id, funct, rs1, rs2, rd, we, committed, killed. Entries are allocated at the tail on an accepted handshake.
- Commit: match commit_id_i against valid, uncommitted entries. A match sets committed, plus killed if commit_kill_i. An unmatched id is ignored. A commit in the same cycle as the issue of the same id applies to the new entry.
- Head FSM:
  - IDLE: head valid && committed && killed -> pop, stay IDLE (1 cycle/entry, no cmd, no result). Head valid && committed && !killed -> DISPATCH.
  - DISPATCH: cmd_valid_o=1 with head fields. On cmd_ready_i -> WAIT_RSP.
  - WAIT_RSP: rsp_ready_o=1. On rsp_valid_i, capture data -> RESULT.
  - RESULT: result_valid_o=1, id/rd/we from head, data = captured if we else 0. On result_ready_i -> pop, IDLE.
- Latency (ready always high): head committed at cycle N -> cmd_valid at N+1. Response handshake at M -> result_valid at M+1.
- Only the head is dispatched, giving in-order results and at most one accelerator transaction outstanding.
- Valid outputs and their payloads are held stable while valid && !ready.
- rsp_valid_i outside WAIT_RSP is not acknowledged.
- Simultaneous issue allocate and head pop: count unchanged, and pointers wrap modulo DEPTH.
- Full queue: issue_ready_o=0, and the commit interface continues to be processed.

Test Plan:
- Issue custom-0 funct3=0, rd=5, id=2, rs1=3, rs2=4; commit id 2; rsp data 0x7 -> accept=1, writeback=1; cmd funct={f7,000}, rs1=3, rs2=4 one cycle after commit; result id=2, rd=5, we=1, data=0x7.
- Issue opcode 0x33 -> handshake completes with accept=0, count stays 0, no cmd.
- Issue ids 1,2,3 then kill 1, commit 2 and 3 -> id 1 popped silently, results only for ids 2 then 3, in order.
- Fill 4 entries with none committed -> issue_ready_o=0. Commit head, complete result -> issue_ready_o=1 the cycle after pop.
- Hold result_ready_i=0 for 5 cycles -> result fields stable and next head not dispatched. Issue a no-writeback op (funct3=4) -> result we=0, data=0.
- Assert rst_i while in WAIT_RSP -> next cycle all valids 0, issue_ready_o=1, and a later rsp_valid_i is not acknowledged.

Source files
------------

// File: rtl/ma_cvxif_responder.sv
// Coprocessor-side CVXIF responder for the matrix accelerator.
// Decodes offloaded custom-0 instructions and keeps accepted ones in an
// in-order queue until they are committed or killed. Only the head entry is
// sent to the accelerator, so results come back in order and at most one
// accelerator transaction is outstanding.
module ma_cvxif_responder #(
  parameter int         XLEN     = 32,
  parameter int         ID_WIDTH = 3,
  parameter int         DEPTH    = 4,
  parameter logic [6:0] OPCODE   = 7'h0B
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [XLEN-1:0]     issue_rs1_i,
  input  logic [XLEN-1:0]     issue_rs2_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o,
  output logic                cmd_valid_o,
  input  logic                cmd_ready_i,
  output logic [9:0]          cmd_funct_o,
  output logic [XLEN-1:0]     cmd_rs1_o,
  output logic [XLEN-1:0]     cmd_rs2_o,
  input  logic                rsp_valid_i,
  output logic                rsp_ready_o,
  input  logic [XLEN-1:0]     rsp_data_i
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                vld;
    logic [ID_WIDTH-1:0] id;
    logic [9:0]          funct;
    logic [XLEN-1:0]     rs1;
    logic [XLEN-1:0]     rs2;
    logic [4:0]          rd;
    logic                we;
    logic                cmt;
    logic                kil;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_WAIT_RSP, S_RESULT} state_e;

  entry_t          q_q [DEPTH];
  entry_t          q_d [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  state_e          state_q, state_d;
  logic [XLEN-1:0] rsp_q, rsp_d;

  logic [2:0] dec_f3;
  logic [4:0] dec_rd;
  logic       dec_accept, dec_wb;
  logic       alloc, pop, issue_cmt_hit;
  logic       head_vld, head_cmt, head_kil;
  logic       unused_instr_bits;

  assign dec_f3            = issue_instr_i[14:12];
  assign dec_rd            = issue_instr_i[11:7];
  assign dec_accept        = (issue_instr_i[6:0] == OPCODE) && (dec_f3 != 3'b111);
  assign dec_wb            = dec_accept && (dec_f3 <= 3'b011) && (dec_rd != 5'd0);
  assign unused_instr_bits = ^issue_instr_i[24:15];

  assign issue_ready_o     = (count_q < CW'(DEPTH));
  assign issue_accept_o    = issue_valid_i & dec_accept;
  assign issue_writeback_o = issue_valid_i & dec_wb;
  assign alloc             = issue_valid_i & issue_ready_o & dec_accept;
  assign issue_cmt_hit     = commit_valid_i && (commit_id_i == issue_id_i);

  // Next-state: commit marking, head FSM, pop at head and allocate at tail.
  always_comb begin
    q_d     = q_q;
    head_d  = head_q;
    tail_d  = tail_q;
    state_d = state_q;
    rsp_d   = rsp_q;
    pop     = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      if (commit_valid_i && q_q[i].vld && !q_q[i].cmt && (q_q[i].id == commit_id_i)) begin
        q_d[i].cmt = 1'b1;
        q_d[i].kil = commit_kill_i;
      end
    end

    // Head view includes this cycle's commit so dispatch starts one cycle after it.
    head_vld = q_d[head_q].vld;
    head_cmt = q_d[head_q].cmt;
    head_kil = q_d[head_q].kil;

    case (state_q)
      S_IDLE: begin
        if (head_vld && head_cmt) begin
          if (head_kil) pop = 1'b1;
          else          state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: if (cmd_ready_i) state_d = S_WAIT_RSP;
      S_WAIT_RSP: begin
        if (rsp_valid_i) begin
          rsp_d   = rsp_data_i;
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (result_ready_i) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      q_d[head_q].vld = 1'b0;
      head_d          = head_q + PW'(1);
    end

    // Tail slot is always free when alloc is possible, so it never aliases the popped head.
    if (alloc) begin
      q_d[tail_q] = '{vld:   1'b1,
                      id:    issue_id_i,
                      funct: {issue_instr_i[31:25], dec_f3},
                      rs1:   issue_rs1_i,
                      rs2:   issue_rs2_i,
                      rd:    dec_rd,
                      we:    dec_wb,
                      cmt:   issue_cmt_hit,
                      kil:   issue_cmt_hit && commit_kill_i};
      tail_d = tail_q + PW'(1);
    end

    count_d = count_q + CW'(alloc) - CW'(pop);
  end

  // State registers with synchronous reset that drops every queued entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_IDLE;
      rsp_q   <= '0;
    end else begin
      q_q     <= q_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      rsp_q   <= rsp_d;
    end
  end

  assign cmd_valid_o    = (state_q == S_DISPATCH);
  assign cmd_funct_o    = cmd_valid_o ? q_q[head_q].funct : '0;
  assign cmd_rs1_o      = cmd_valid_o ? q_q[head_q].rs1 : '0;
  assign cmd_rs2_o      = cmd_valid_o ? q_q[head_q].rs2 : '0;
  assign rsp_ready_o    = (state_q == S_WAIT_RSP);
  assign result_valid_o = (state_q == S_RESULT);
  assign result_id_o    = result_valid_o ? q_q[head_q].id : '0;
  assign result_rd_o    = result_valid_o ? q_q[head_q].rd : '0;
  assign result_we_o    = result_valid_o & q_q[head_q].we;
  assign result_data_o  = (result_valid_o && q_q[head_q].we) ? rsp_q : '0;
endmodule

// File: tb/tb_ma_cvxif_responder.sv
// Self-checking bench for ma_cvxif_responder: decode table, directed
// multi-cycle sequences and a randomized run against a queue-based model.
`timescale 1ns/1ps
module tb_ma_cvxif_responder;
  localparam int XLEN = 32;
  localparam int IDW  = 3;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            issue_valid, issue_ready_o, issue_accept_o, issue_writeback_o;
  logic [31:0]     issue_instr;
  logic [IDW-1:0]  issue_id;
  logic [XLEN-1:0] issue_rs1, issue_rs2;
  logic            commit_valid, commit_kill;
  logic [IDW-1:0]  commit_id;
  logic            result_valid_o, result_ready, result_we_o;
  logic [IDW-1:0]  result_id_o;
  logic [XLEN-1:0] result_data_o;
  logic [4:0]      result_rd_o;
  logic            cmd_valid_o, cmd_ready;
  logic [9:0]      cmd_funct_o;
  logic [XLEN-1:0] cmd_rs1_o, cmd_rs2_o;
  logic            rsp_valid, rsp_ready_o;
  logic [XLEN-1:0] rsp_data;

  always #5 clk = ~clk;

  ma_cvxif_responder #(.XLEN(XLEN), .ID_WIDTH(IDW), .DEPTH(4), .OPCODE(7'h0B)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready_o), .issue_instr_i(issue_instr),
    .issue_id_i(issue_id), .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready), .result_id_o(result_id_o),
    .result_data_o(result_data_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready), .cmd_funct_o(cmd_funct_o),
    .cmd_rs1_o(cmd_rs1_o), .cmd_rs2_o(cmd_rs2_o),
    .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready_o), .rsp_data_i(rsp_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {f7, 5'd0, 5'd0, f3, rd, op};
  endfunction

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic clr();
    issue_valid = 0; issue_instr = 0; issue_id = 0; issue_rs1 = 0; issue_rs2 = 0;
    commit_valid = 0; commit_id = 0; commit_kill = 0;
    result_ready = 0; cmd_ready = 0; rsp_valid = 0; rsp_data = 0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [IDW-1:0] id,
                       input logic [31:0] a, input logic [31:0] b);
    issue_valid = 1; issue_instr = ins; issue_id = id; issue_rs1 = a; issue_rs2 = b;
  endtask

  task automatic commit(input logic [IDW-1:0] id, input logic kill);
    commit_valid = 1; commit_id = id; commit_kill = kill;
  endtask

  // ---------------- decode table ----------------
  typedef struct {
    logic [31:0] instr;
    logic        acc;
    logic        wb;
  } dec_vec_t;
  dec_vec_t dv [8];

  // ---------------- directed service helper ----------------
  logic [IDW-1:0]  sv_id[$];
  logic [4:0]      sv_rd[$];
  logic [XLEN-1:0] sv_data[$];
  int              sv_ncmd, sv_nrsp;

  task automatic service(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      nxt(); clr();
      cmd_ready = 1; result_ready = 1; rsp_valid = 1; rsp_data = 32'h50 + sv_nrsp;
      #1;
      if (cmd_valid_o) sv_ncmd++;
      if (rsp_ready_o) sv_nrsp++;
      if (result_valid_o) begin
        sv_id.push_back(result_id_o); sv_rd.push_back(result_rd_o); sv_data.push_back(result_data_o);
      end
    end
  endtask

  // ---------------- reference model for random run ----------------
  typedef struct {
    logic [IDW-1:0]  id;
    logic [9:0]      funct;
    logic [XLEN-1:0] rs1, rs2;
    logic [4:0]      rd;
    logic            we, cmt, kil, disp;
  } mentry_t;
  mentry_t         mq[$];
  logic [XLEN-1:0] last_rsp;
  int              n_res;

  function automatic bit id_busy(input logic [IDW-1:0] id);
    foreach (mq[i]) if (!mq[i].kil && mq[i].id == id) return 1;
    return 0;
  endfunction

  function automatic int live_entries();
    int n = 0;
    foreach (mq[i]) if (!mq[i].kil) n++;
    return n;
  endfunction

  task automatic purge_killed();
    while (mq.size() > 0 && mq[0].cmt && mq[0].kil) void'(mq.pop_front());
  endtask

  task automatic rand_cycle(input bit drain);
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [IDW-1:0] iid, cid;
    bit do_issue, do_commit, ckill, exp_acc, exp_wb;
    int cand[$];
    mentry_t ne;
    nxt(); clr();
    cmd_ready    = drain ? 1'b1 : ($urandom_range(3) != 0);
    result_ready = drain ? 1'b1 : ($urandom_range(2) != 0);
    rsp_valid    = 1'($urandom_range(1));
    rsp_data     = $urandom();
    do_issue = 0; do_commit = 0; iid = 0; cid = 0; op = 0; f3 = 0; rd = 0; f7 = 0;
    if (!drain && $urandom_range(1) == 1) begin
      iid = 3'($urandom_range(7));
      if (!id_busy(iid)) begin
        op = ($urandom_range(3) != 0) ? 7'h0B : 7'h33;
        f3 = 3'($urandom_range(7));
        rd = 5'($urandom_range(31));
        f7 = 7'($urandom_range(127));
        issue(mk(f7, f3, rd, op), iid, $urandom(), $urandom());
        do_issue = 1;
      end
    end
    ckill = ($urandom_range(3) == 0);
    if (do_issue && $urandom_range(7) == 0) begin
      cid = iid; do_commit = 1;
    end else if (drain || $urandom_range(1) == 1) begin
      foreach (mq[i]) if (!mq[i].cmt) cand.push_back(i);
      if (cand.size() > 0) begin
        cid = mq[cand[$urandom_range(cand.size() - 1)]].id;
        do_commit = 1;
      end
    end
    if (do_commit) commit(cid, ckill);
    #1;
    if (cmd_valid_o && cmd_ready) begin
      purge_killed();
      if (mq.size() == 0) chk("rnd_cmd_unexpected", 1, 0);
      else begin
        chk("rnd_cmd_order", {mq[0].cmt, mq[0].kil, mq[0].disp}, 3'b100);
        chk("rnd_cmd_funct", cmd_funct_o, mq[0].funct);
        chk("rnd_cmd_rs1", cmd_rs1_o, mq[0].rs1);
        chk("rnd_cmd_rs2", cmd_rs2_o, mq[0].rs2);
        mq[0].disp = 1;
      end
    end
    if (rsp_valid && rsp_ready_o) last_rsp = rsp_data;
    if (result_valid_o && result_ready) begin
      purge_killed();
      if (mq.size() == 0) chk("rnd_res_unexpected", 1, 0);
      else begin
        chk("rnd_res_disp", mq[0].disp, 1);
        chk("rnd_res_id", result_id_o, mq[0].id);
        chk("rnd_res_rd", result_rd_o, mq[0].rd);
        chk("rnd_res_we", result_we_o, mq[0].we);
        chk("rnd_res_data", result_data_o, mq[0].we ? last_rsp : 32'h0);
        void'(mq.pop_front());
        n_res++;
      end
    end
    if (do_commit) begin
      foreach (mq[i]) if (!mq[i].cmt && mq[i].id == cid) begin
        mq[i].cmt = 1; mq[i].kil = ckill;
      end
    end
    if (do_issue && issue_ready_o) begin
      exp_acc = (op == 7'h0B) && (f3 != 3'd7);
      exp_wb  = exp_acc && (f3 < 3'd4) && (rd != 5'd0);
      chk("rnd_accept", issue_accept_o, exp_acc);
      chk("rnd_writeback", issue_writeback_o, exp_wb);
      if (exp_acc) begin
        ne.id = iid; ne.funct = {f7, f3}; ne.rs1 = issue_rs1; ne.rs2 = issue_rs2;
        ne.rd = rd; ne.we = exp_wb; ne.disp = 0;
        ne.cmt = do_commit && (cid == iid);
        ne.kil = ne.cmt && ckill;
        mq.push_back(ne);
      end
    end
  endtask

  initial begin
    dv[0] = '{mk(7'h12, 3'd0, 5'd5,  7'h0B), 1'b1, 1'b1};
    dv[1] = '{mk(7'h00, 3'd3, 5'd1,  7'h0B), 1'b1, 1'b1};
    dv[2] = '{mk(7'h7F, 3'd4, 5'd5,  7'h0B), 1'b1, 1'b0};
    dv[3] = '{mk(7'h01, 3'd7, 5'd5,  7'h0B), 1'b0, 1'b0};
    dv[4] = '{mk(7'h02, 3'd0, 5'd0,  7'h0B), 1'b1, 1'b0};
    dv[5] = '{mk(7'h00, 3'd0, 5'd5,  7'h33), 1'b0, 1'b0};
    dv[6] = '{mk(7'h00, 3'd1, 5'd5,  7'h2B), 1'b0, 1'b0};
    dv[7] = '{mk(7'h05, 3'd6, 5'd31, 7'h0B), 1'b1, 1'b0};

    clr(); rst_i = 1;
    repeat (3) nxt();
    chk("rst_cmd_valid", cmd_valid_o, 0);
    chk("rst_result_valid", result_valid_o, 0);
    chk("rst_rsp_ready", rsp_ready_o, 0);
    chk("rst_result_fields", {result_id_o, result_rd_o, result_we_o, result_data_o}, 0);
    chk("rst_accept_wb", {issue_accept_o, issue_writeback_o}, 0);
    rst_i = 0;

    // decode table: combinational only, valid dropped before the clock edge
    for (int i = 0; i < 8; i++) begin
      nxt(); clr();
      issue(dv[i].instr, 3'd0, 0, 0);
      #1;
      chk($sformatf("dec%0d_accept", i), issue_accept_o, dv[i].acc);
      chk($sformatf("dec%0d_wb", i), issue_writeback_o, dv[i].wb);
      issue_valid = 0;
    end

    // basic issue / commit / dispatch / result
    nxt(); clr(); issue(mk(7'h12, 3'd0, 5'd5, 7'h0B), 3'd2, 32'd3, 32'd4); #1;
    chk("t1_accept", issue_accept_o, 1);
    chk("t1_wb", issue_writeback_o, 1);
    chk("t1_ready", issue_ready_o, 1);
    nxt(); clr(); commit(3'd2, 0);
    chk("t1_no_cmd_before_commit", cmd_valid_o, 0);
    nxt(); clr();
    chk("t1_cmd_valid", cmd_valid_o, 1);
    chk("t1_cmd_funct", cmd_funct_o, 10'h090);
    chk("t1_cmd_rs", {cmd_rs1_o, cmd_rs2_o}, {32'd3, 32'd4});
    cmd_ready = 1;
    nxt(); clr();
    chk("t1_rsp_ready", rsp_ready_o, 1);
    chk("t1_cmd_dropped", cmd_valid_o, 0);
    rsp_valid = 1; rsp_data = 32'h7;
    nxt(); clr();
    chk("t1_res_valid", result_valid_o, 1);
    chk("t1_res_fields", {result_id_o, result_rd_o, result_we_o}, {3'd2, 5'd5, 1'b1});
    chk("t1_res_data", result_data_o, 32'h7);
    result_ready = 1;
    nxt(); clr();
    chk("t1_res_done", {result_valid_o, rsp_ready_o, cmd_valid_o}, 0);

    // non-accepted opcode
    nxt(); clr(); issue(mk(7'h00, 3'd0, 5'd5, 7'h33), 3'd1, 1, 1); #1;
    chk("t2_accept", issue_accept_o, 0);
    chk("t2_ready", issue_ready_o, 1);
    nxt(); clr(); commit(3'd1, 0);
    nxt(); clr();
    nxt(); clr();
    chk("t2_no_cmd", cmd_valid_o, 0);

    // kill head, commit the rest: results 2 then 3
    for (int k = 1; k <= 3; k++) begin
      nxt(); clr(); issue(mk(7'(k), 3'd0, 5'(10 + k), 7'h0B), 3'(k), 32'(k), 32'(k));
    end
    nxt(); clr(); commit(3'd1, 1);
    nxt(); clr(); commit(3'd2, 0);
    nxt(); clr(); commit(3'd3, 0);
    sv_ncmd = 0; sv_nrsp = 0; sv_id.delete(); sv_rd.delete(); sv_data.delete();
    service(20);
    chk("t3_ncmd", sv_ncmd, 2);
    chk("t3_nres", sv_id.size(), 2);
    if (sv_id.size() == 2) begin
      chk("t3_order", {sv_id[0], sv_id[1]}, {3'd2, 3'd3});
      chk("t3_rd", {sv_rd[0], sv_rd[1]}, {5'd12, 5'd13});
      chk("t3_data", {sv_data[0], sv_data[1]}, {32'h50, 32'h51});
    end

    // full queue, commit while full, ready returns after pop
    for (int k = 4; k <= 7; k++) begin
      nxt(); clr(); issue(mk(7'h00, 3'd0, 5'd1, 7'h0B), 3'(k), 0, 0);
    end
    nxt(); clr();
    chk("t4_full", issue_ready_o, 0);
    issue(mk(7'h00, 3'd0, 5'd1, 7'h0B), 3'd0, 0, 0);
    commit(3'd4, 0);
    nxt(); clr();
    chk("t4_commit_while_full", cmd_valid_o, 1);
    cmd_ready = 1;
    nxt(); clr(); rsp_valid = 1; rsp_data = 32'h99;
    nxt(); clr();
    chk("t4_res", {result_valid_o, result_id_o, issue_ready_o}, {1'b1, 3'd4, 1'b0});
    result_ready = 1;
    nxt(); clr();
    chk("t4_ready_after_pop", issue_ready_o, 1);
    nxt(); clr(); commit(3'd5, 1);
    nxt(); clr(); commit(3'd6, 1);
    nxt(); clr(); commit(3'd7, 1);
    nxt(); clr(); commit(3'd0, 0);
    repeat (3) begin nxt(); clr(); end
    chk("t4_no_ghost_entry", cmd_valid_o, 0);

    // result back-pressure and a no-writeback op
    nxt(); clr(); issue(mk(7'h21, 3'd4, 5'd9, 7'h0B), 3'd1, 32'h5, 32'h6); #1;
    chk("t5_wb0", {issue_accept_o, issue_writeback_o}, 2'b10);
    nxt(); clr(); issue(mk(7'h22, 3'd1, 5'd3, 7'h0B), 3'd2, 32'h11, 32'h22); commit(3'd1, 0);
    nxt(); clr(); commit(3'd2, 0);
    chk("t5_cmd1", {cmd_valid_o, cmd_funct_o}, {1'b1, 10'h10C});
    cmd_ready = 1;
    nxt(); clr(); rsp_valid = 1; rsp_data = 32'hDEAD;
    for (int c = 0; c < 5; c++) begin
      nxt(); clr();
      chk("t5_hold_res", {result_valid_o, result_id_o, result_rd_o, result_we_o}, {1'b1, 3'd1, 5'd9, 1'b0});
      chk("t5_hold_data", result_data_o, 0);
      chk("t5_hold_no_dispatch", cmd_valid_o, 0);
    end
    nxt(); clr(); result_ready = 1;
    chk("t5_res_still", result_valid_o, 1);
    nxt(); clr();
    chk("t5_idle_gap", {result_valid_o, cmd_valid_o}, 0);
    nxt(); clr();
    chk("t5_cmd2", {cmd_valid_o, cmd_funct_o, cmd_rs1_o}, {1'b1, 10'h111, 32'h11});
    cmd_ready = 1;
    nxt(); clr(); rsp_valid = 1; rsp_data = 32'h33;
    nxt(); clr();
    chk("t5_res2", {result_id_o, result_rd_o, result_we_o, result_data_o}, {3'd2, 5'd3, 1'b1, 32'h33});
    result_ready = 1;
    nxt(); clr();
    chk("t5_done", result_valid_o, 0);

    // reset while waiting for the accelerator
    nxt(); clr(); issue(mk(7'h00, 3'd0, 5'd4, 7'h0B), 3'd3, 0, 0);
    nxt(); clr(); commit(3'd3, 0);
    nxt(); clr(); chk("t6_cmd", cmd_valid_o, 1); cmd_ready = 1;
    nxt(); clr(); chk("t6_wait", rsp_ready_o, 1); rst_i = 1;
    nxt(); clr(); rst_i = 0;
    chk("t6_after_rst", {cmd_valid_o, rsp_ready_o, result_valid_o, issue_ready_o}, 4'b0001);
    rsp_valid = 1; rsp_data = 32'h5;
    nxt(); clr(); rsp_valid = 1; rsp_data = 32'h5;
    chk("t6_rsp_not_acked", rsp_ready_o, 0);
    nxt(); clr();
    chk("t6_no_result", {result_valid_o, cmd_valid_o}, 0);

    // randomized run against the queue model
    mq.delete(); n_res = 0; last_rsp = 0;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b0);
    begin
      int guard = 0;
      while ((live_entries() > 0) && guard < 400) begin
        rand_cycle(1'b1);
        guard++;
      end
      chk("rnd_drained", live_entries(), 0);
    end
    repeat (6) begin nxt(); clr(); end
    chk("rnd_final_idle", {issue_ready_o, cmd_valid_o, result_valid_o}, 3'b100);
    chk("rnd_progress", n_res > 50, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
